// File: rtl/axis_pkt_checker.sv
// rtl/axis_pkt_checker.sv - AXI-Stream packet sink checking routing, length, payload and sequence
//
// Purpose: terminal sink on one mesh output port. Parses {SRC,LEN,SEQ} headers and
// checks dest, source id, per-source sequence, payload words and packet length.
// Keeps saturating packet/beat/error counters and a sticky first-error code.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           backpressure request; axis_s_tready follows ~stall one cycle later
//   axis_s_*        AXI-Stream slave (tvalid/tready/tdata/tlast/tdest)
//   pkt_cnt         packets completed (tlast accepted), saturating
//   beat_cnt        beats accepted, saturating
//   err_cnt         packets with at least one error, saturating
//   err_code        first error since reset: 0 none,1 DEST,2 LEN,3 DATA,4 SEQ,5 SRC
//   done            high once pkt_cnt >= EXPECT_PKTS, until reset
module axis_pkt_checker #(
  parameter int TDATAW      = 32,
  parameter int TDESTW      = 4,
  parameter int MY_DEST     = 0,
  parameter int NUM_SRC     = 4,
  parameter int EXPECT_PKTS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              axis_s_tvalid,
  output logic              axis_s_tready,
  input  logic [TDATAW-1:0] axis_s_tdata,
  input  logic              axis_s_tlast,
  input  logic [TDESTW-1:0] axis_s_tdest,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       beat_cnt,
  output logic [15:0]       err_cnt,
  output logic [2:0]        err_code,
  output logic              done
);

  localparam logic [2:0] E_NONE = 3'd0, E_DEST = 3'd1, E_LEN = 3'd2,
                         E_DATA = 3'd3, E_SEQ  = 3'd4, E_SRC = 3'd5;

  typedef enum logic [1:0] {S_HDR, S_PAY, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        tready_q, tready_d;
  logic [7:0]  src_q, src_d, len_q, len_d, idx_q, idx_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] exp_seq_q [NUM_SRC];
  logic [15:0] exp_seq_d [NUM_SRC];
  logic        pkt_err_q, pkt_err_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d, beat_cnt_q, beat_cnt_d, err_cnt_q, err_cnt_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        done_q, done_d;

  logic        acc, dest_ok, src_ok;
  logic [7:0]  hdr_src, hdr_len;
  logic [15:0] hdr_seq, hdr_exp;
  logic [2:0]  beat_code;

  assign acc     = axis_s_tvalid & tready_q;
  assign dest_ok = (axis_s_tdest == TDESTW'(MY_DEST));
  assign hdr_src = axis_s_tdata[31:24];
  assign hdr_len = axis_s_tdata[23:16];
  assign hdr_seq = axis_s_tdata[15:0];
  assign src_ok  = (hdr_src < 8'(NUM_SRC));

  always_comb begin
    state_d    = state_q;
    tready_d   = ~stall;
    src_d      = src_q;
    len_d      = len_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    exp_seq_d  = exp_seq_q;
    pkt_err_d  = pkt_err_q;
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_code_d = err_code_q;
    beat_code  = E_NONE;
    hdr_exp    = '0;

    // Illegal source ids have no table entry; the lookup stays 0 but is never used then.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hdr_src == 8'(i)) hdr_exp = exp_seq_q[i];
    end

    case (state_q)
      S_HDR: begin
        if (acc) begin
          src_d = hdr_src;
          len_d = hdr_len;
          seq_d = hdr_seq;
          idx_d = 8'd1;
          if (!dest_ok)                                  beat_code = E_DEST;
          else if (!src_ok)                              beat_code = E_SRC;
          else if (hdr_seq != hdr_exp)                   beat_code = E_SEQ;
          else if (axis_s_tlast ^ (hdr_len == 8'd0))     beat_code = E_LEN;
          // Table always follows the last seen sequence so one gap costs one error.
          if (src_ok) begin
            for (int i = 0; i < NUM_SRC; i++) begin
              if (hdr_src == 8'(i)) exp_seq_d[i] = hdr_seq + 16'd1;
            end
          end
          // A zero-length header without tlast has no payload to compare against.
          if (!axis_s_tlast) begin
            if (!dest_ok || !src_ok || hdr_len == 8'd0) state_d = S_DRAIN;
            else                                       state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (acc) begin
          if (axis_s_tdata != {seq_q, src_q, idx_q}) beat_code = E_DATA;
          else if (!dest_ok)                         beat_code = E_DEST;
          if (axis_s_tlast && idx_q < len_q) begin
            if (beat_code == E_NONE) beat_code = E_LEN;
            state_d = S_HDR;
          end else if (idx_q == len_q && !axis_s_tlast) begin
            if (beat_code == E_NONE) beat_code = E_LEN;
            state_d = S_DRAIN;
          end else if (idx_q == len_q) begin
            state_d = S_HDR;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (acc && axis_s_tlast) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase

    if (acc) begin
      if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
      pkt_err_d = pkt_err_q | (beat_code != E_NONE);
      if (err_code_q == E_NONE) err_code_d = beat_code;
      if (axis_s_tlast) begin
        if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
        if (pkt_err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        pkt_err_d = 1'b0;
      end
    end

    done_d = done_q | (pkt_cnt_d >= 16'(EXPECT_PKTS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      tready_q   <= 1'b0;
      src_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      seq_q      <= '0;
      for (int i = 0; i < NUM_SRC; i++) exp_seq_q[i] <= '0;
      pkt_err_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_code_q <= E_NONE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tready_q   <= tready_d;
      src_q      <= src_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      exp_seq_q  <= exp_seq_d;
      pkt_err_q  <= pkt_err_d;
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
    end
  end

  assign axis_s_tready = tready_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign beat_cnt      = beat_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign err_code      = err_code_q;
  assign done          = done_q;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// tb/tb_axis_pkt_checker.sv - randomized self-checking bench for axis_pkt_checker
module tb_axis_pkt_checker;

  localparam int MY_DEST = 0;
  localparam int NUM_SRC = 4;
  localparam int EXPECT_PKTS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [3:0]  tdest;
  logic [15:0] pkt_cnt, beat_cnt, err_cnt;
  logic [2:0]  err_code;
  logic        done;

  axis_pkt_checker #(
    .TDATAW(32), .TDESTW(4), .MY_DEST(MY_DEST), .NUM_SRC(NUM_SRC), .EXPECT_PKTS(EXPECT_PKTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .axis_s_tvalid(tvalid), .axis_s_tready(tready), .axis_s_tdata(tdata),
    .axis_s_tlast(tlast), .axis_s_tdest(tdest),
    .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
    .err_code(err_code), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  bit stall_en = 0;
  bit gaps = 0;

  // Packet-level reference model: counters, first error, expected next sequence per source.
  int m_pkt, m_beat, m_err, m_code;
  int m_exp [NUM_SRC];

  initial begin
    int scnt;
    scnt = 0;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_en) begin
        scnt++;
        if (scnt == 3) begin
          stall = ~stall;
          scnt = 0;
        end
      end else begin
        stall = 1'b0;
        scnt = 0;
      end
    end
  end

  task automatic model_clear();
    m_pkt = 0; m_beat = 0; m_err = 0; m_code = 0;
    for (int i = 0; i < NUM_SRC; i++) m_exp[i] = 0;
  endtask

  task automatic model_pkt(input int src, input int len, input int seq, input int dest,
                           input int nbeats, input int corrupt);
    int code;
    code = 0;
    if (dest != MY_DEST)                      code = 1;
    else if (src >= NUM_SRC)                  code = 5;
    else if (seq != m_exp[src])               code = 4;
    else if ((nbeats == 1) != (len == 0))     code = 2;
    if (src < NUM_SRC) m_exp[src] = (seq + 1) % 65536;
    if (code == 0 && corrupt != 0)            code = 3;
    if (code == 0 && nbeats < len + 1)        code = 2;
    m_pkt++;
    m_beat += nbeats;
    if (code != 0) m_err++;
    if (m_code == 0) m_code = code;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] dst, input logic last);
    int  bound;
    bit  accepted;
    bound = 0;
    accepted = 0;
    while (!accepted) begin
      @(negedge clk);
      if (gaps && $urandom_range(3) == 0) begin
        tvalid = 1'b0;
      end else begin
        tvalid = 1'b1;
        tdata = d;
        tdest = dst;
        tlast = last;
        accepted = tready;
      end
      @(posedge clk);
      bound++;
      if (!accepted && bound > 300) begin
        total++;
        $display("FAIL beat_timeout: tready=%0b after %0d cycles, required accept", tready, bound);
        accepted = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    tvalid = 1'b0;
    tlast = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input int src, input int len, input int seq, input int dest,
                          input int nbeats, input int corrupt);
    logic [31:0] w;
    w = {src[7:0], len[7:0], seq[15:0]};
    send_beat(w, dest[3:0], nbeats == 1);
    for (int i = 1; i < nbeats; i++) begin
      w = {seq[15:0], src[7:0], i[7:0]};
      if (i == corrupt) w = w ^ 32'h8000_0000;
      send_beat(w, dest[3:0], i == nbeats - 1);
    end
    model_pkt(src, len, seq, dest, nbeats, corrupt);
  endtask

  task automatic send_good();
    int src, len;
    src = $urandom_range(NUM_SRC - 1);
    len = $urandom_range(5);
    send_pkt(src, len, m_exp[src], MY_DEST, len + 1, 0);
  endtask

  task automatic do_reset();
    stall_en = 0;
    gaps = 0;
    tvalid = 1'b0;
    tlast = 1'b0;
    tdata = '0;
    tdest = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    total++;
    if (pkt_cnt !== 16'(m_pkt)) $display("FAIL %s pkt_cnt: got %0d want %0d", tag, pkt_cnt, m_pkt);
    else passed++;
    total++;
    if (beat_cnt !== 16'(m_beat)) $display("FAIL %s beat_cnt: got %0d want %0d", tag, beat_cnt, m_beat);
    else passed++;
    total++;
    if (err_cnt !== 16'(m_err)) $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, m_err);
    else passed++;
    total++;
    if (err_code !== 3'(m_code)) $display("FAIL %s err_code: got %0d want %0d", tag, err_code, m_code);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tvalid = 1'b0;
    tlast = 1'b0;
    tdata = '0;
    tdest = '0;
    #1;
    total++;
    if (tready !== 1'b0) $display("FAIL reset_tready: got %0b want 0", tready); else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passed++;
    model_clear();
    check_all("reset");
    do_reset();
    total++;
    if (tready !== 1'b1) $display("FAIL ready_after_reset: got %0b want 1", tready); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    send_pkt(1, 2, 0, MY_DEST, 3, 0);
    idle(2);
    check_all("basic");
    total++;
    if (pkt_cnt !== 16'd1 || beat_cnt !== 16'd3)
      $display("FAIL basic_literal: pkt=%0d beat=%0d want 1/3", pkt_cnt, beat_cnt);
    else passed++;
  endtask

  task automatic test_seq();
    do_reset();
    send_pkt(1, 1, 0, MY_DEST, 2, 0);
    send_pkt(1, 1, 5, MY_DEST, 2, 0);
    idle(2);
    check_all("seq_gap");
    send_pkt(1, 3, 6, MY_DEST, 4, 0);
    idle(2);
    check_all("seq_resync");
  endtask

  task automatic test_len();
    do_reset();
    send_pkt(3, 3, 0, MY_DEST, 3, 0);
    idle(2);
    check_all("len_short");
    send_pkt(3, 2, 1, MY_DEST, 3, 0);
    send_pkt(2, 0, 0, MY_DEST, 1, 0);
    idle(2);
    check_all("len_recover");
  endtask

  task automatic test_dest_src_data();
    do_reset();
    send_pkt(0, 4, 0, 3, 5, 0);
    idle(2);
    check_all("dest_drain");
    do_reset();
    send_pkt(9, 2, 0, MY_DEST, 3, 0);
    send_pkt(0, 1, 0, MY_DEST, 2, 0);
    idle(2);
    check_all("src_illegal");
    do_reset();
    send_pkt(2, 4, 0, MY_DEST, 5, 3);
    idle(2);
    check_all("data_corrupt");
  endtask

  task automatic test_stream();
    do_reset();
    stall_en = 1;
    gaps = 1;
    for (int p = 0; p < EXPECT_PKTS - 1; p++) send_good();
    idle(2);
    total++;
    if (done !== 1'b0) $display("FAIL done_early: got %0b want 0 at %0d pkts", done, pkt_cnt); else passed++;
    send_good();
    idle(2);
    total++;
    if (done !== 1'b1) $display("FAIL done_set: got %0b want 1", done); else passed++;
    check_all("stream");
    stall_en = 0;
    gaps = 0;
  endtask

  task automatic test_random();
    int kind, src, len, seq, dest, nb, cor;
    do_reset();
    gaps = 1;
    for (int p = 0; p < 30; p++) begin
      kind = $urandom_range(5);
      src = $urandom_range(NUM_SRC - 1);
      len = $urandom_range(6);
      seq = m_exp[src];
      dest = MY_DEST;
      nb = len + 1;
      cor = 0;
      case (kind)
        1: seq = (seq + $urandom_range(1, 100)) % 65536;
        2: src = $urandom_range(255, NUM_SRC);
        3: dest = $urandom_range(15, 1);
        4: if (len > 0) cor = $urandom_range(len, 1);
        5: if (len >= 2) nb = $urandom_range(len, 2);
        default: ;
      endcase
      send_pkt(src, len, seq, dest, nb, cor);
    end
    idle(2);
    check_all("random");
    gaps = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_pkt(1, 1, 0, MY_DEST, 2, 0);
    send_beat({8'd2, 8'd4, 16'd0}, 4'(MY_DEST), 1'b0);
    send_beat({16'd0, 8'd2, 8'd1}, 4'(MY_DEST), 1'b0);
    @(negedge clk);
    tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (tready !== 1'b0) $display("FAIL midrst_tready: got %0b want 0", tready); else passed++;
    total++;
    if (beat_cnt !== 16'd0 || pkt_cnt !== 16'd0)
      $display("FAIL midrst_cnt: beat=%0d pkt=%0d want 0/0", beat_cnt, pkt_cnt);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    send_pkt(2, 2, 0, MY_DEST, 3, 0);
    idle(2);
    check_all("after_midrst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seq();
    test_len();
    test_dest_src_data();
    test_stream();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
